window_reader: RTL and testbench

Reads convolution windows out of the image RAM that the address setter fills. For each output position it fetches a K×K window in row-major order, with K = 3 or 5 and stride 1 or 2, and streams the pixels to the MAC array over a valid/ready interface. It is the read-side counterpart of the setter's linear write sweep and shares its 17-bit address space, its `FILTER`/`STRIDE` encoding and its `ACK`-on-completion convention.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/pix_fifo2.sv | 52 +++++
 rtl/window_reader.sv | 182 ++++++++++++++++++
 tb/tb_window_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN image-RAM blocks.
// Holds default bus widths, the FILTER/STRIDE encodings, the window reader
// state enum and a helper that maps the FILTER bit to the window size K.
package cnn_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic FILTER_3X3 = 1'b0;
  localparam logic FILTER_5X5 = 1'b1;
  localparam logic STRIDE_1   = 1'b0;
  localparam logic STRIDE_2   = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } win_state_e;

  // Window edge length K for a given FILTER encoding.
  function automatic int unsigned win_k(input logic filter);
    return (filter == FILTER_5X5) ? 5 : 3;
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO between the RAM read port and the pixel stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry (caller guarantees space)
//   pop        : drop the head entry (caller guarantees non-empty)
//   rdata      : head entry
//   count      : occupancy, 0..2
module pix_fifo2 #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/window_reader.sv
// Streams KxK convolution windows out of the image RAM in raster order.
// Windows are visited oy-then-ox; pixels inside a window ky-then-kx.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, filter, stride, base : pass request and its captured settings
//   mem_rd, mem_adrs       : RAM read strobe/address
//   mem_data               : RAM data, valid the cycle after mem_rd
//   pix_data/valid/ready/last : pixel stream to the MAC array
//   busy, ack              : pass in progress / one-cycle completion pulse
module window_reader
  import cnn_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              filter,
  input  logic              stride,
  input  logic [ADDR_W-1:0] base,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_adrs,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              ack
);

  localparam int unsigned CNT_W = 16;

  win_state_e        state_q, state_d;
  logic              filter_q, filter_d;
  logic              stride_q, stride_d;
  logic [CNT_W-1:0]  kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_W-1:0] line_q, line_d;  // origin of the current row of windows
  logic [ADDR_W-1:0] win_q, win_d;    // origin of the current window
  logic [ADDR_W-1:0] row_q, row_d;    // start of the current row inside the window
  logic              inflight_q;
  logic              inflight_last_q;

  logic [CNT_W-1:0]  k_last, oc_last, or_last;
  logic [ADDR_W-1:0] win_step, line_step;
  logic              win_last;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_rdata;
  logic              room;

  assign k_last    = CNT_W'(win_k(filter_q) - 1);
  assign oc_last   = CNT_W'((IMG_W - win_k(filter_q)) >> stride_q);
  assign or_last   = CNT_W'((IMG_H - win_k(filter_q)) >> stride_q);
  assign win_step  = stride_q ? ADDR_W'(2) : ADDR_W'(1);
  assign line_step = stride_q ? ADDR_W'(IMG_W << 1) : ADDR_W'(IMG_W);
  assign win_last  = (kx_q == k_last) && (ky_q == k_last);

  assign pix_valid = (fifo_count != 2'd0);
  assign pix_data  = fifo_rdata[DATA_W-1:0];
  assign pix_last  = pix_valid & fifo_rdata[DATA_W];
  assign pop       = pix_valid & pix_ready;

  // Reads already in flight occupy a FIFO slot before their data lands.
  assign room     = ({1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;
  assign mem_rd   = (state_q == StFetch) && room;
  assign mem_adrs = row_q + ADDR_W'(kx_q);

  assign busy = (state_q == StFetch) || (state_q == StDrain);
  assign ack  = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    filter_d = filter_q;
    stride_d = stride_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    line_d   = line_q;
    win_d    = win_q;
    row_d    = row_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFetch;
          filter_d = filter;
          stride_d = stride;
          kx_d     = '0;
          ky_d     = '0;
          ox_d     = '0;
          oy_d     = '0;
          line_d   = base;
          win_d    = base;
          row_d    = base;
        end
      end
      StFetch: begin
        if (mem_rd) begin
          if (kx_q != k_last) begin
            kx_d = kx_q + CNT_W'(1);
          end else begin
            kx_d = '0;
            if (ky_q != k_last) begin
              ky_d  = ky_q + CNT_W'(1);
              row_d = row_q + ADDR_W'(IMG_W);
            end else begin
              ky_d = '0;
              if (ox_q != oc_last) begin
                ox_d  = ox_q + CNT_W'(1);
                win_d = win_q + win_step;
                row_d = win_q + win_step;
              end else if (oy_q != or_last) begin
                ox_d   = '0;
                oy_d   = oy_q + CNT_W'(1);
                line_d = line_q + line_step;
                win_d  = line_q + line_step;
                row_d  = line_q + line_step;
              end else begin
                state_d = StDrain;
              end
            end
          end
        end
      end
      StDrain: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      filter_q        <= FILTER_3X3;
      stride_q        <= STRIDE_1;
      kx_q            <= '0;
      ky_q            <= '0;
      ox_q            <= '0;
      oy_q            <= '0;
      line_q          <= '0;
      win_q           <= '0;
      row_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      filter_q        <= filter_d;
      stride_q        <= stride_d;
      kx_q            <= kx_d;
      ky_q            <= ky_d;
      ox_q            <= ox_d;
      oy_q            <= oy_d;
      line_q          <= line_d;
      win_q           <= win_d;
      row_q           <= row_d;
      inflight_q      <= mem_rd;
      inflight_last_q <= mem_rd & win_last;
    end
  end

  pix_fifo2 #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight_q),
    .wdata({inflight_last_q, mem_data}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_window_reader.sv
// Randomized self-checking bench for window_reader on an 8x8 image.
module tb_window_reader;

  localparam int IMG = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, filter, stride;
  logic [16:0] base;
  logic        mem_rd;
  logic [16:0] mem_adrs;
  logic [7:0]  mem_data = 8'd0;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_ready, pix_last, busy, ack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [16:0] exp_rd_q[$];
  logic [8:0]  exp_px_q[$];
  logic [16:0] rd_log[$];
  int rd_cnt, px_cnt, ack_cnt;
  int first_rd_cyc, first_v_cyc, first_hs, last_hs, ack_cyc, start_cyc;
  bit rand_ready = 1'b0;
  bit stall_q = 1'b0;
  logic [8:0] stall_val;

  window_reader #(
    .ADDR_W(17),
    .DATA_W(8),
    .IMG_W (IMG),
    .IMG_H (IMG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .filter   (filter),
    .stride   (stride),
    .base     (base),
    .mem_rd   (mem_rd),
    .mem_adrs (mem_adrs),
    .mem_data (mem_data),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last (pix_last),
    .busy     (busy),
    .ack      (ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM model: data is the low byte of the address, one cycle later.
  always @(posedge clk) mem_data <= mem_adrs[7:0];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pass: every read address and every pixel in stream order.
  function automatic void build(input bit f, input bit s, input logic [16:0] b);
    int k, st, n;
    logic [16:0] a;
    k  = f ? 5 : 3;
    st = s ? 2 : 1;
    n  = (IMG - k) / st + 1;
    exp_rd_q.delete();
    exp_px_q.delete();
    for (int oy = 0; oy < n; oy++)
      for (int ox = 0; ox < n; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            a = 17'(int'(b) + (oy * st + ky) * IMG + ox * st + kx);
            exp_rd_q.push_back(a);
            exp_px_q.push_back({(ky == k - 1) && (kx == k - 1), a[7:0]});
          end
  endfunction

  task automatic clear_stats();
    rd_cnt = 0; px_cnt = 0; ack_cnt = 0;
    first_rd_cyc = -1; first_v_cyc = -1; first_hs = -1; last_hs = -1; ack_cyc = -1;
    rd_log.delete();
    stall_q = 1'b0;
  endtask

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_occupancy",
              32'((rd_cnt + 1 - px_cnt - ((pix_valid && pix_ready) ? 1 : 0)) <= 2), 32'd1);
        rd_log.push_back(mem_adrs);
        if (exp_rd_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
        else check("rd_adrs", 32'(mem_adrs), 32'(exp_rd_q.pop_front()));
        rd_cnt++;
      end
      if (stall_q) begin
        check("stall_valid", 32'(pix_valid), 32'd1);
        check("stall_data", 32'({pix_last, pix_data}), 32'(stall_val));
      end
      if (pix_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (pix_valid && pix_ready) begin
        if (exp_px_q.size() == 0) check("px_extra", 32'd1, 32'd0);
        else check("px", 32'({pix_last, pix_data}), 32'(exp_px_q.pop_front()));
        px_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      stall_q   = pix_valid && !pix_ready;
      stall_val = {pix_last, pix_data};
      if (ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        check("ack_busy", 32'(busy), 32'd0);
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic run_pass(input bit f, input bit s, input logic [16:0] b, input bit rr,
                          input bit poke, input int npix);
    build(f, s, b);
    clear_stats();
    rand_ready = rr;
    @(posedge clk);
    #1;
    start = 1'b1; filter = f; stride = s; base = b;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    // Scramble the settings: they must have been captured with start.
    start = 1'b0; filter = ~f; stride = ~s; base = 17'h0abcd;
    if (poke) begin
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1; filter = 1'b1; stride = 1'b1; base = 17'h00055;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 5000 && ack_cnt == 0; i++) @(posedge clk);
    if (ack_cnt == 0) check("ack_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("ack_count", 32'(ack_cnt), 32'd1);
    check("px_count", 32'(px_cnt), 32'(npix));
    check("rd_left", 32'(exp_rd_q.size()), 32'd0);
    check("px_left", 32'(exp_px_q.size()), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("lat_rd", 32'(first_rd_cyc - start_cyc), 32'd1);
    check("lat_valid", 32'(first_v_cyc - start_cyc), 32'd3);
    check("ack_delay", 32'(ack_cyc - last_hs), 32'd2);
    if (!rr) check("throughput", 32'(last_hs - first_hs), 32'(npix - 1));
    rand_ready = 1'b0;
  endtask

  task automatic reset_mid();
    build(1'b0, 1'b0, 17'd0);
    clear_stats();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; filter = 1'b0; stride = 1'b0; base = 17'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && px_cnt < 50; i++) @(posedge clk);
    check("rst_reach50", 32'(px_cnt), 32'd50);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_adrs", 32'(mem_adrs), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_last", 32'(pix_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_ack", 32'(ack_cnt), 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [16:0] t1_exp[9];
    t1_exp = '{17'd0, 17'd1, 17'd2, 17'd8, 17'd9, 17'd10, 17'd16, 17'd17, 17'd18};
    rst_n = 1'b0; start = 1'b0; filter = 1'b0; stride = 1'b0; base = 17'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_adrs", 32'(mem_adrs), 32'd0);
    check("reset_valid", 32'(pix_valid), 32'd0);
    check("reset_data", 32'(pix_data), 32'd0);
    check("reset_last", 32'(pix_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;

    run_pass(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 324);
    for (int i = 0; i < 9; i++) check("t1_first_win", 32'(rd_log[i]), 32'(t1_exp[i]));

    run_pass(1'b1, 1'b1, 17'h00100, 1'b0, 1'b0, 100);
    check("t2_win0", 32'(rd_log[0]), 32'h100);
    check("t2_win1", 32'(rd_log[25]), 32'h102);
    check("t2_win2", 32'(rd_log[50]), 32'h110);

    run_pass(1'b0, 1'b0, 17'h1ffff, 1'b0, 1'b0, 324);
    check("t3_wrap0", 32'(rd_log[0]), 32'h1ffff);
    check("t3_wrap1", 32'(rd_log[1]), 32'h00000);
    check("t3_wrap2", 32'(rd_log[2]), 32'h00001);

    run_pass(1'b0, 1'b0, 17'd0, 1'b1, 1'b0, 324);
    run_pass(1'b0, 1'b0, 17'h00040, 1'b1, 1'b1, 324);

    reset_mid();
    run_pass(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 324);
    check("t6_restart0", 32'(rd_log[0]), 32'd0);
    check("t6_restart3", 32'(rd_log[3]), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
